shift_reg_sr: RTL and testbench

//  Clocked, edge-triggered storage stage fed by the gated D/SR latch; replaces level-sensitive capture with a

---
 rtl/shift_reg_sr_if.sv | 32 +++
 rtl/shift_reg_sr.sv | 84 ++++++++
 tb/tb_shift_reg_sr.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_sr_if.sv
// Bus bundle for the universal shift register: control, burst request and register outputs.
// The slave modport is the register; the master modport is whoever drives it.
interface shift_reg_sr_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             set_n;
   logic             g;
   logic [1:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin_r;
   logic             sin_l;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             dir;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_n;
   logic             sout_r;
   logic             sout_l;
   logic             busy;
   logic             done;

   modport slave (
      input  set_n, g, mode, d, sin_r, sin_l, start, len, dir,
      output q, q_n, sout_r, sout_l, busy, done
   );

   modport master (
      output set_n, g, mode, d, sin_r, sin_l, start, len, dir,
      input  q, q_n, sout_r, sout_l, busy, done
   );
endinterface

// File: rtl/shift_reg_sr.sv
// WIDTH-bit universal shift register (hold/right/left/load) with a burst engine that performs
// len consecutive shifts from one start pulse and flags completion with a one-cycle done.
module shift_reg_sr #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   shift_reg_sr_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] shiftRight;
   logic [WIDTH-1:0] shiftLeft;

   // Serial inputs are taken live on every shift edge, burst or not.
   assign shiftRight = {bus.sin_r, data_q[WIDTH-1:1]};
   assign shiftLeft  = {data_q[WIDTH-2:0], bus.sin_l};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   // Priority: preset, then gate freeze, then an active burst, then a new start, then mode.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;

      if (!bus.set_n) begin
         data_d  = '1;
         state_d = IDLE;
         cnt_d   = '0;
      end else if (bus.g) begin
         if (state_q == SHIFT) begin
            data_d = dir_q ? shiftLeft : shiftRight;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end else if (bus.start) begin
            dir_d   = bus.dir;
            cnt_d   = bus.len;
            state_d = (bus.len != '0) ? SHIFT : DONE;
         end else begin
            state_d = IDLE;
            unique case (bus.mode)
               2'b00:   data_d = data_q;
               2'b01:   data_d = shiftRight;
               2'b10:   data_d = shiftLeft;
               default: data_d = bus.d;
            endcase
         end
      end
   end

   assign bus.q      = data_q;
   assign bus.q_n    = ~data_q;
   assign bus.sout_r = data_q[0];
   assign bus.sout_l = data_q[WIDTH-1];
   assign bus.busy   = (state_q == SHIFT);
   assign bus.done   = (state_q == DONE);

endmodule

// File: tb/tb_shift_reg_sr.sv
// Directed bench for shift_reg_sr (WIDTH=8, CNT_W=4): hand-computed vectors checked
// with immediate assertions one time unit after each rising edge.
module tb_shift_reg_sr;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic clk;
   logic reset_n;
   int   evalCount;
   int   failCount;

   shift_reg_sr_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) busIf ();

   shift_reg_sr #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (busIf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      evalCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] mode, input logic [7:0] d,
                                input logic start, input logic [3:0] len, input logic dir);
      busIf.mode  = mode;
      busIf.d     = d;
      busIf.start = start;
      busIf.len   = len;
      busIf.dir   = dir;
   endtask

   task automatic checkState(input string tag, input logic [7:0] q,
                             input logic busy, input logic done);
      checkOutput({tag, ".q"}, 32'(busIf.q), 32'(q));
      checkOutput({tag, ".busy"}, 32'(busIf.busy), 32'(busy));
      checkOutput({tag, ".done"}, 32'(busIf.done), 32'(done));
   endtask

   initial begin
      evalCount = 0;
      failCount = 0;
      reset_n      = 1'b0;
      busIf.set_n  = 1'b1;
      busIf.g      = 1'b1;
      busIf.sin_r  = 1'b0;
      busIf.sin_l  = 1'b0;
      applyStimulus(2'b00, 8'h00, 1'b0, 4'd0, 1'b0);
      #2;
      checkState("reset", 8'h00, 1'b0, 1'b0);
      checkOutput("reset.q_n", 32'(busIf.q_n), 32'hFF);
      #10 reset_n = 1'b1;

      // Parallel load, single right and left shifts
      applyStimulus(2'b11, 8'hA5, 1'b0, 4'd0, 1'b0);
      tick();
      checkOutput("load.q", 32'(busIf.q), 32'hA5);
      busIf.sin_r = 1'b1;
      applyStimulus(2'b01, 8'h00, 1'b0, 4'd0, 1'b0);
      tick();
      checkOutput("shr.q", 32'(busIf.q), 32'hD2);
      busIf.sin_l = 1'b0;
      applyStimulus(2'b10, 8'h00, 1'b0, 4'd0, 1'b0);
      tick();
      checkOutput("shl.q", 32'(busIf.q), 32'hA4);
      checkOutput("shl.q_n", 32'(busIf.q_n), 32'h5B);
      checkOutput("shl.sout_r", 32'(busIf.sout_r), 32'h0);
      checkOutput("shl.sout_l", 32'(busIf.sout_l), 32'h1);
      applyStimulus(2'b00, 8'h00, 1'b0, 4'd0, 1'b0);
      tick();
      checkOutput("hold.q", 32'(busIf.q), 32'hA4);

      // Burst of 3 right shifts from 81
      applyStimulus(2'b11, 8'h81, 1'b0, 4'd0, 1'b0);
      tick();
      busIf.sin_r = 1'b0;
      applyStimulus(2'b00, 8'h00, 1'b1, 4'd3, 1'b0);
      tick();
      checkState("b3.start", 8'h81, 1'b1, 1'b0);
      applyStimulus(2'b00, 8'h00, 1'b0, 4'd0, 1'b0);
      tick();
      checkState("b3.s1", 8'h40, 1'b1, 1'b0);
      tick();
      checkState("b3.s2", 8'h20, 1'b1, 1'b0);
      tick();
      checkState("b3.s3", 8'h10, 1'b0, 1'b1);
      tick();
      checkState("b3.idle", 8'h10, 1'b0, 1'b0);

      // Zero-length burst, start ignored while busy, start accepted on DONE
      applyStimulus(2'b00, 8'h00, 1'b1, 4'd0, 1'b0);
      tick();
      checkState("len0.done", 8'h10, 1'b0, 1'b1);
      applyStimulus(2'b00, 8'h00, 1'b0, 4'd0, 1'b0);
      tick();
      checkState("len0.idle", 8'h10, 1'b0, 1'b0);
      busIf.sin_l = 1'b1;
      applyStimulus(2'b00, 8'h00, 1'b1, 4'd2, 1'b1);
      tick();
      checkState("b2.start", 8'h10, 1'b1, 1'b0);
      applyStimulus(2'b11, 8'hEE, 1'b1, 4'd5, 1'b0);
      tick();
      checkState("b2.s1", 8'h21, 1'b1, 1'b0);
      tick();
      checkState("b2.s2", 8'h43, 1'b0, 1'b1);
      applyStimulus(2'b11, 8'hEE, 1'b1, 4'd1, 1'b0);
      tick();
      checkState("b2b.start", 8'h43, 1'b1, 1'b0);
      applyStimulus(2'b00, 8'h00, 1'b0, 4'd0, 1'b0);
      tick();
      checkState("b2b.s1", 8'h21, 1'b0, 1'b1);
      tick();
      checkState("b2b.idle", 8'h21, 1'b0, 1'b0);

      // Burst of 4 with the gate low for 2 cycles, then done stretched by the gate
      applyStimulus(2'b11, 8'h0F, 1'b0, 4'd0, 1'b0);
      tick();
      busIf.sin_r = 1'b1;
      applyStimulus(2'b00, 8'h00, 1'b1, 4'd4, 1'b0);
      tick();
      applyStimulus(2'b00, 8'h00, 1'b0, 4'd0, 1'b0);
      tick();
      checkState("g.s1", 8'h87, 1'b1, 1'b0);
      busIf.g = 1'b0;
      tick();
      checkState("g.p1", 8'h87, 1'b1, 1'b0);
      tick();
      checkState("g.p2", 8'h87, 1'b1, 1'b0);
      busIf.g = 1'b1;
      tick();
      checkState("g.s2", 8'hC3, 1'b1, 1'b0);
      tick();
      checkState("g.s3", 8'hE1, 1'b1, 1'b0);
      tick();
      checkState("g.s4", 8'hF0, 1'b0, 1'b1);
      busIf.g = 1'b0;
      tick();
      checkState("g.stretch", 8'hF0, 1'b0, 1'b1);
      busIf.g = 1'b1;
      tick();
      checkState("g.idle", 8'hF0, 1'b0, 1'b0);

      // Preset during a frozen burst, and preset beating parallel load
      applyStimulus(2'b11, 8'h3C, 1'b0, 4'd0, 1'b0);
      tick();
      busIf.sin_l = 1'b0;
      applyStimulus(2'b00, 8'h00, 1'b1, 4'd5, 1'b1);
      tick();
      applyStimulus(2'b00, 8'h00, 1'b0, 4'd0, 1'b0);
      tick();
      checkState("set.s1", 8'h78, 1'b1, 1'b0);
      busIf.g     = 1'b0;
      busIf.set_n = 1'b0;
      tick();
      checkState("set.abort", 8'hFF, 1'b0, 1'b0);
      busIf.g     = 1'b1;
      busIf.set_n = 1'b1;
      tick();
      checkState("set.after", 8'hFF, 1'b0, 1'b0);
      busIf.set_n = 1'b0;
      applyStimulus(2'b11, 8'h12, 1'b0, 4'd0, 1'b0);
      tick();
      checkOutput("set.vs_load", 32'(busIf.q), 32'hFF);
      busIf.set_n = 1'b1;
      tick();
      checkOutput("load.after_set", 32'(busIf.q), 32'h12);

      // Asynchronous reset in the middle of a burst with cnt=3
      applyStimulus(2'b11, 8'h5A, 1'b0, 4'd0, 1'b0);
      tick();
      busIf.sin_r = 1'b1;
      applyStimulus(2'b00, 8'h00, 1'b1, 4'd5, 1'b0);
      tick();
      applyStimulus(2'b00, 8'h00, 1'b0, 4'd0, 1'b0);
      tick();
      tick();
      checkState("rst.pre", 8'hD6, 1'b1, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      checkState("rst.async", 8'h00, 1'b0, 1'b0);
      checkOutput("rst.q_n", 32'(busIf.q_n), 32'hFF);
      reset_n = 1'b1;
      tick();
      checkState("rst.release", 8'h00, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
      $finish;
   end

endmodule
